// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the host command UART receiver.
// Imported by the byte receiver and the frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_ARM     = 8'h01;
    localparam logic [7:0] CMD_RESET   = 8'h02;
    localparam logic [7:0] CMD_SET_WIN = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        HUNT,
        CMD,
        PAY,
        CHK
    } parse_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-FF input synchroniser plus bit-timing FSM.
// Emits one-cycle byte_valid / frame_err pulses.
module uart_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       active
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            sync_a;
    logic            sync_b;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_n;
    logic [7:0]      shift;
    logic [7:0]      shift_n;
    logic            valid_n;
    logic            ferr_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= rx;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = '0;
                if (!sync_b) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    // A start bit that is gone by mid-bit was line noise.
                    state_n = sync_b ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shift_n = {sync_b, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (sync_b) begin
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HI;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_HI: begin
                if (sync_b) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_byte = shift;
    assign active  = (state != IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: assembles A5,CMD,P0..P3,CHK frames from the UART
// byte stream and reports accepted commands or frame/checksum/timeout errors.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_Rx,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [31:0] payload,
    output logic        frame_err,
    output logic        chk_err,
    output logic        to_err,
    output logic        busy
);

    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);

    logic         rx_bv;
    logic [7:0]   rx_byte;
    logic         rx_fe;
    logic         rx_active;

    parse_state_t state;
    parse_state_t state_n;
    logic [7:0]   cmd_sh;
    logic [31:0]  payload_sh;
    logic [7:0]   sum;
    logic [1:0]   pay_idx;
    logic [GW-1:0] gap;
    logic         fire;
    logic         bad;
    logic         tmo;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (i_Rx),
        .byte_valid(rx_bv),
        .rx_byte   (rx_byte),
        .frame_err (rx_fe),
        .active    (rx_active)
    );

    always_comb begin
        state_n = state;
        fire    = 1'b0;
        bad     = 1'b0;
        tmo     = 1'b0;
        if (rx_bv) begin
            unique case (state)
                HUNT: if (rx_byte == SYNC_BYTE) state_n = CMD;
                CMD:  state_n = PAY;
                PAY:  if (pay_idx == 2'd3) state_n = CHK;
                CHK: begin
                    state_n = HUNT;
                    if (rx_byte == sum) fire = 1'b1;
                    else bad = 1'b1;
                end
                default: state_n = HUNT;
            endcase
        end else if (rx_fe && state != HUNT) begin
            state_n = HUNT;
        end else if (state != HUNT && gap == GAP_LAST) begin
            tmo     = 1'b1;
            state_n = HUNT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= HUNT;
        else state <= state_n;
    end

    // Gap counter only runs inside a frame; any received byte restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gap <= '0;
        else if (state == HUNT || rx_bv) gap <= '0;
        else gap <= gap + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_sh     <= '0;
            payload_sh <= '0;
            sum        <= '0;
            pay_idx    <= '0;
        end else if (rx_bv) begin
            if (state == CMD) begin
                cmd_sh  <= rx_byte;
                sum     <= rx_byte;
                pay_idx <= '0;
            end else if (state == PAY) begin
                payload_sh[8*pay_idx +: 8] <= rx_byte;
                sum     <= sum + rx_byte;
                pay_idx <= pay_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            chk_err   <= 1'b0;
            to_err    <= 1'b0;
            cmd       <= '0;
            payload   <= '0;
        end else begin
            cmd_valid <= fire;
            chk_err   <= bad;
            to_err    <= tmo;
            if (fire) begin
                cmd     <= cmd_sh;
                payload <= payload_sh;
            end
        end
    end

    assign frame_err = rx_fe;
    assign busy      = rx_active | (state != HUNT);

endmodule
